// File: rtl/i2c_master_word_ctrl.sv
// Word-level I2C command sequencer: turns one host command into START, DATA_W data
// bits, one ACK bit and an optional STOP on the bit controller, with arbitration abort.
module i2c_master_word_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cmd_valid,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Read,
  input  logic              Write,
  input  logic              Tx_ack,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              Rx_ack,
  output logic              Busy,
  output logic              I2C_done,
  output logic              I2C_al,
  output logic [3:0]        Bit_cmd,
  output logic              Bit_txd,
  input  logic              Bit_rxd,
  input  logic              Bit_ack,
  input  logic              Bit_al
);
  // state | meaning
  // IDLE  | no command in progress, Cmd_valid accepted
  // START | START bit command outstanding
  // DATA  | data bits in flight, cnt = bits already acknowledged
  // ACK   | acknowledge bit (read after a write, write after a read)
  // STOP  | STOP bit command outstanding
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, dout_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              c_stop, c_rd, c_wr, c_tx_ack;
  logic              stop_n, rd_n, wr_n, tx_ack_n;
  logic              busy_n, done_n, al_n, rx_ack_n, txd_n, finish;
  logic [3:0]        bit_cmd_n;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    dout_n    = Dout;
    rx_ack_n  = Rx_ack;
    busy_n    = Busy;
    done_n    = 1'b0;
    al_n      = 1'b0;
    finish    = 1'b0;
    stop_n    = c_stop;
    rd_n      = c_rd;
    wr_n      = c_wr;
    tx_ack_n  = c_tx_ack;
    bit_cmd_n = CMD_NOP;
    txd_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (Cmd_valid) begin
          stop_n   = Stop;
          wr_n     = Write;
          rd_n     = Read & ~Write;
          tx_ack_n = Tx_ack;
          shreg_n  = Din;
          cnt_n    = '0;
          busy_n   = Start | Read | Write | Stop;
          if (Start)              state_n = S_START;
          else if (Read | Write)  state_n = S_DATA;
          else if (Stop)          state_n = S_STOP;
          else                    done_n  = 1'b1;
        end
      end
      default: begin
        // arbitration loss wins over a coincident Bit_ack
        if (Bit_al) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          al_n    = 1'b1;
        end else if (Bit_ack) begin
          case (state)
            S_START: begin
              if (c_rd | c_wr)  state_n = S_DATA;
              else if (c_stop)  state_n = S_STOP;
              else              finish  = 1'b1;
            end
            S_DATA: begin
              shreg_n = c_wr ? (shreg << 1) : ((shreg << 1) | DATA_W'(Bit_rxd));
              cnt_n   = cnt + 1'b1;
              if (cnt == CNT_W'(DATA_W - 1)) state_n = S_ACK;
            end
            S_ACK: begin
              if (c_wr) rx_ack_n = Bit_rxd;
              else      dout_n   = shreg;
              if (c_stop) state_n = S_STOP;
              else        finish  = 1'b1;
            end
            S_STOP:  finish = 1'b1;
            default: finish = 1'b0;
          endcase
        end
      end
    endcase

    if (finish) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
    end

    // bit command is a function of the state being entered (or held)
    case (state_n)
      S_START: bit_cmd_n = CMD_START;
      S_DATA: begin
        if (wr_n) begin
          bit_cmd_n = CMD_WRITE;
          txd_n     = shreg_n[DATA_W-1];
        end else begin
          bit_cmd_n = CMD_READ;
        end
      end
      S_ACK: begin
        if (wr_n) begin
          bit_cmd_n = CMD_READ;
        end else begin
          bit_cmd_n = CMD_WRITE;
          txd_n     = tx_ack_n;
        end
      end
      S_STOP:  bit_cmd_n = CMD_STOP;
      default: bit_cmd_n = CMD_NOP;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      Dout     <= '0;
      Rx_ack   <= 1'b0;
      Busy     <= 1'b0;
      I2C_done <= 1'b0;
      I2C_al   <= 1'b0;
      Bit_cmd  <= CMD_NOP;
      Bit_txd  <= 1'b0;
      c_stop   <= 1'b0;
      c_rd     <= 1'b0;
      c_wr     <= 1'b0;
      c_tx_ack <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      Dout     <= dout_n;
      Rx_ack   <= rx_ack_n;
      Busy     <= busy_n;
      I2C_done <= done_n;
      I2C_al   <= al_n;
      Bit_cmd  <= bit_cmd_n;
      Bit_txd  <= txd_n;
      c_stop   <= stop_n;
      c_rd     <= rd_n;
      c_wr     <= wr_n;
      c_tx_ack <= tx_ack_n;
    end
  end

endmodule

// File: tb/tb_i2c_master_word_ctrl.sv
// Bench for i2c_master_word_ctrl: emulates the bit controller and checks the issued
// bit-command stream and results against a command-level model (widths 8, 16 and 1).
module tb_i2c_master_word_ctrl;
  localparam int NOP = 0, STA = 1, STO = 2, WR = 4, RD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       cmd_valid, start, stop, read, write, tx_ack, bit_rxd, bit_ack, bit_al;
  logic [7:0] din, dout;
  logic       rx_ack, busy, done, al, bit_txd;
  logic [3:0] bit_cmd;

  logic        cmd_valid16, read16, bit_rxd16, bit_ack16;
  logic [15:0] din16, dout16;
  logic        rx_ack16, busy16, done16, al16, bit_txd16;
  logic [3:0]  bit_cmd16;

  logic        cmd_valid1, write1, bit_rxd1, bit_ack1;
  logic [0:0]  din1, dout1;
  logic        rx_ack1, busy1, done1, al1, bit_txd1;
  logic [3:0]  bit_cmd1;

  i2c_master_word_ctrl #(.DATA_W(8)) dut (
    .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid), .Start(start), .Stop(stop),
    .Read(read), .Write(write), .Tx_ack(tx_ack), .Din(din), .Dout(dout),
    .Rx_ack(rx_ack), .Busy(busy), .I2C_done(done), .I2C_al(al),
    .Bit_cmd(bit_cmd), .Bit_txd(bit_txd), .Bit_rxd(bit_rxd), .Bit_ack(bit_ack), .Bit_al(bit_al));

  i2c_master_word_ctrl #(.DATA_W(16)) dut16 (
    .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid16), .Start(1'b0), .Stop(1'b0),
    .Read(read16), .Write(1'b0), .Tx_ack(1'b0), .Din(din16), .Dout(dout16),
    .Rx_ack(rx_ack16), .Busy(busy16), .I2C_done(done16), .I2C_al(al16),
    .Bit_cmd(bit_cmd16), .Bit_txd(bit_txd16), .Bit_rxd(bit_rxd16), .Bit_ack(bit_ack16), .Bit_al(1'b0));

  i2c_master_word_ctrl #(.DATA_W(1)) dut1 (
    .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid1), .Start(1'b0), .Stop(1'b0),
    .Read(1'b0), .Write(write1), .Tx_ack(1'b0), .Din(din1), .Dout(dout1),
    .Rx_ack(rx_ack1), .Busy(busy1), .I2C_done(done1), .I2C_al(al1),
    .Bit_cmd(bit_cmd1), .Bit_txd(bit_txd1), .Bit_rxd(bit_rxd1), .Bit_ack(bit_ack1), .Bit_al(1'b0));

  typedef struct {
    logic       start, stop, rd, wr, tx_ack;
    logic [7:0] din, rxw;
    logic       rxa;
    logic [7:0] exp_dout;
    logic       exp_rx_ack;
  } vec_t;

  vec_t       tbl[8];
  int         q_cmd[$];
  int         q_txd[$];
  logic       q_rxd[$];
  int         n_tests = 0, n_fail = 0;
  logic [7:0] m_dout;
  logic       m_rx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected bit-level transaction for one command, derived from the command fields.
  task automatic build(input vec_t v);
    logic [7:0] d = v.din;
    logic [7:0] r = v.rxw;
    q_cmd.delete(); q_txd.delete(); q_rxd.delete();
    if (v.start) begin q_cmd.push_back(STA); q_txd.push_back(0); q_rxd.push_back(1'b0); end
    if (v.rd | v.wr) begin
      for (int i = 0; i < 8; i++) begin
        if (v.wr) begin q_cmd.push_back(WR); q_txd.push_back(int'(d[7])); q_rxd.push_back(1'b0); end
        else      begin q_cmd.push_back(RD); q_txd.push_back(0);          q_rxd.push_back(r[7]); end
        d = d << 1;
        r = r << 1;
      end
      if (v.wr) begin q_cmd.push_back(RD); q_txd.push_back(0); q_rxd.push_back(v.rxa); end
      else      begin q_cmd.push_back(WR); q_txd.push_back(int'(v.tx_ack)); q_rxd.push_back(1'b0); end
    end
    if (v.stop) begin q_cmd.push_back(STO); q_txd.push_back(0); q_rxd.push_back(1'b0); end
  endtask

  task automatic issue(input vec_t v);
    start = v.start; stop = v.stop; read = v.rd; write = v.wr; tx_ack = v.tx_ack; din = v.din;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    // command fields must have been latched; scramble them
    start = 1'($urandom); stop = 1'($urandom); read = 1'($urandom);
    write = 1'($urandom); tx_ack = 1'($urandom); din = 8'($urandom);
  endtask

  task automatic service(input int al_at, input logic [7:0] e_dout, input logic e_rx);
    for (int n = 0; n < q_cmd.size(); n++) begin
      int w = int'($urandom_range(0, 2));
      for (int k = 0; k <= w; k++) begin
        if (k > 0) tick();
        chk("bit_cmd", 32'(bit_cmd), q_cmd[n]);
        if (q_cmd[n] == WR) chk("bit_txd", 32'(bit_txd), q_txd[n]);
        chk("busy_held", 32'(busy), 1);
      end
      bit_ack = 1'b1; bit_rxd = q_rxd[n]; bit_al = (n == al_at);
      tick();
      bit_ack = 1'b0; bit_al = 1'b0; bit_rxd = 1'($urandom);
      if (n == al_at) begin
        chk("al_pulse", 32'(al), 1);
        chk("al_busy", 32'(busy), 0);
        chk("al_cmd", 32'(bit_cmd), NOP);
        chk("al_no_done", 32'(done), 0);
        chk("al_dout", 32'(dout), 32'(e_dout));
        chk("al_rx_ack", 32'(rx_ack), 32'(e_rx));
        return;
      end
    end
    chk("done", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_cmd", 32'(bit_cmd), NOP);
    chk("done_no_al", 32'(al), 0);
    chk("dout", 32'(dout), 32'(e_dout));
    chk("rx_ack", 32'(rx_ack), 32'(e_rx));
  endtask

  initial begin
    vec_t v;
    logic [15:0] w16;

    //          start stop  rd    wr    txack din    rxw    rxa   dout   rx_ack
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, 8'h3C, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 8'hC3, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h81, 8'hFF, 1'b0, 8'hC3, 1'b0};

    rst = 1'b1;
    {cmd_valid, start, stop, read, write, tx_ack, bit_rxd, bit_ack, bit_al} = '0;
    din = '0;
    {cmd_valid16, read16, bit_rxd16, bit_ack16} = '0; din16 = '0;
    {cmd_valid1, write1, bit_rxd1, bit_ack1} = '0; din1 = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(bit_cmd), NOP);
    chk("rst_txd", 32'(bit_txd), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_rx_ack", 32'(rx_ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_al", 32'(al), 0);
    chk("rst_dout16", 32'(dout16), 0);
    rst = 1'b0;
    tick();

    bit_ack = 1'b1; bit_rxd = 1'b1;
    tick();
    bit_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 0);
    chk("idle_ack_cmd", 32'(bit_cmd), NOP);
    chk("idle_ack_done", 32'(done), 0);

    for (int t = 0; t < 8; t++) begin
      build(tbl[t]);
      issue(tbl[t]);
      service(-1, tbl[t].exp_dout, tbl[t].exp_rx_ack);
      tick();
      chk("done_pulse_end", 32'(done), 0);
    end
    m_dout = 8'hC3;
    m_rx   = 1'b0;

    // arbitration lost on the 4th data ack of a read
    v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h96, 1'b0, 8'h00, 1'b0};
    build(v);
    issue(v);
    service(3, m_dout, m_rx);
    tick();
    chk("al_one_cycle", 32'(al), 0);
    chk("al_still_idle", 32'(bit_cmd), NOP);

    // Cmd_valid while busy is ignored
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h96, 8'h00, 1'b1, 8'h00, 1'b0};
    build(v);
    issue(v);
    start = 1'b1; stop = 1'b1; read = 1'b1; write = 1'b0; din = 8'h00;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("busy_ignore_cmd", 32'(bit_cmd), WR);
    chk("busy_ignore_txd", 32'(bit_txd), 1);
    m_rx = 1'b1;
    service(-1, m_dout, m_rx);

    // reset in the middle of the data phase
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0};
    issue(v);
    for (int i = 0; i < 5; i++) begin
      bit_ack = 1'b1;
      tick();
    end
    bit_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cmd", 32'(bit_cmd), NOP);
    chk("mid_rst_txd", 32'(bit_txd), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_rx_ack", 32'(rx_ack), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_al", 32'(al), 0);
    m_dout = 8'h00;
    m_rx   = 1'b0;
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0};
    build(v);
    issue(v);
    service(-1, m_dout, m_rx);

    // randomized back-to-back commands, issued in the done cycle
    for (int it = 0; it < 60; it++) begin
      int al_at = -1;
      v.start = 1'($urandom); v.stop = 1'($urandom); v.rd = 1'($urandom);
      v.wr = 1'($urandom); v.tx_ack = 1'($urandom);
      v.din = 8'($urandom); v.rxw = 8'($urandom); v.rxa = 1'($urandom);
      build(v);
      if (q_cmd.size() > 0 && $urandom_range(0, 5) == 0)
        al_at = int'($urandom_range(0, q_cmd.size() - 1));
      // ACK bit completes before any later abort can discard it
      if ((v.rd | v.wr) && (al_at < 0 || al_at > (v.start ? 9 : 8))) begin
        if (v.wr) m_rx = v.rxa;
        else      m_dout = v.rxw;
      end
      issue(v);
      service(al_at, m_dout, m_rx);
    end

    // 16-bit read of BEEF
    w16 = 16'hBEEF;
    read16 = 1'b1; cmd_valid16 = 1'b1;
    tick();
    cmd_valid16 = 1'b0; read16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("w16_read_cmd", 32'(bit_cmd16), RD);
      bit_ack16 = 1'b1; bit_rxd16 = w16[15];
      w16 = w16 << 1;
      tick();
    end
    bit_ack16 = 1'b0;
    chk("w16_ack_cmd", 32'(bit_cmd16), WR);
    chk("w16_ack_txd", 32'(bit_txd16), 0);
    bit_ack16 = 1'b1;
    tick();
    bit_ack16 = 1'b0;
    chk("w16_done", 32'(done16), 1);
    chk("w16_dout", 32'(dout16), 32'h0000BEEF);

    // 1-bit write
    din1 = 1'b1; write1 = 1'b1; cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0; write1 = 1'b0; din1 = 1'b0;
    chk("w1_cmd", 32'(bit_cmd1), WR);
    chk("w1_txd", 32'(bit_txd1), 1);
    bit_ack1 = 1'b1;
    tick();
    chk("w1_ack_cmd", 32'(bit_cmd1), RD);
    bit_rxd1 = 1'b1;
    tick();
    bit_ack1 = 1'b0;
    chk("w1_done", 32'(done1), 1);
    chk("w1_rx_ack", 32'(rx_ack1), 1);
    chk("w1_busy", 32'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_word_ctrl.md
Name: i2c_master_word_ctrl

Overview:
Parametrised successor to the byte-level I2C command controller. It takes one command (any combination of start, write/read, ack phase and stop) from the register/host layer and sequences the bit-level controller through START, DATA_W data bits, one ACK bit and an optional STOP. Unlike the byte-only generation, it owns its own shift register, has a generic word width, a Busy/handshake interface and arbitration-loss abort. It sits between the host register file and i2c_master_bit_ctrl.

Parameters:
DATA_W, 8, data bits per transfer before the ACK bit (legal range 1..32).
CNT_W, $clog2(DATA_W+1), bit counter width (derived, not overridden).

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous active-high reset
Cmd_valid  in  1  command strobe, accepted only when Busy=0
Start  in  1  issue START (or repeated START) first
Stop  in  1  issue STOP last
Read  in  1  read DATA_W bits
Write  in  1  write DATA_W bits (wins over Read if both set)
Tx_ack  in  1  ACK bit driven after a read (0=ACK, 1=NACK)
Din  in  DATA_W  write data, MSB sent first
Dout  out  DATA_W  read data, valid from I2C_done
Rx_ack  out  1  ACK bit sampled from slave after a write
Busy  out  1  command in progress
I2C_done  out  1  one-cycle pulse, command completed
I2C_al  out  1  one-cycle pulse, arbitration lost, command aborted
Bit_cmd  out  4  to bit ctrl: NOP 0000, START 0001, STOP 0010, WRITE 0100, READ 1000 (i2c_master_defines codes)
Bit_txd  out  1  to bit ctrl: data bit for WRITE command
Bit_rxd  in  1  from bit ctrl: sampled SDA, valid with Bit_ack
Bit_ack  in  1  from bit ctrl: one-cycle pulse, current bit command finished
Bit_al  in  1  from bit ctrl: arbitration lost

Behaviour:
- Clock and reset: one clock Clk; reset Rst is synchronous, active-high. Reset values: state IDLE, Busy 0, Bit_cmd NOP, Bit_txd 0, Dout 0, Rx_ack 0, I2C_done 0, I2C_al 0, shift reg 0, counter 0. Rst mid-command abandons it immediately. Bit_cmd is NOP on the next cycle, and no done or al pulse is generated.
- All outputs are registered.
- States: IDLE, START, DATA, ACK, STOP.
- IDLE:
  - On Cmd_valid, latch Start/Stop/Read/Write/Tx_ack, load Din into the shift reg, clear the counter, and set Busy.
  - Next state is START if Start, else DATA if Read|Write, else STOP if Stop.
  - If none of these is set, pulse I2C_done the next cycle and Busy stays 0.
  - Cmd_valid while Busy=1 is ignored.
- Bit_cmd for the new state appears on the edge that enters that state. It is held until Bit_ack, and exactly one bit command is issued per Bit_ack.
- START: Bit_cmd=START. On Bit_ack go to DATA if Read|Write, else STOP if Stop, else finish.
- DATA, write:
  - Bit_cmd=WRITE and Bit_txd=shreg[DATA_W-1].
  - On Bit_ack, shift left with 0 fill, increment the counter, and update Bit_txd to the new MSB on the same edge.
- DATA, read:
  - Bit_cmd=READ.
  - On Bit_ack, shreg <= {shreg[DATA_W-2:0], Bit_rxd} and increment the counter.
- DATA exits to ACK on the Bit_ack that brings the counter to DATA_W. The counter never exceeds DATA_W.
- ACK, after a write: Bit_cmd=READ. On Bit_ack, Rx_ack <= Bit_rxd.
- ACK, after a read: Bit_cmd=WRITE and Bit_txd=latched Tx_ack. On Bit_ack, Dout <= shreg.
- ACK exits to STOP if Stop, else finish.
- STOP: Bit_cmd=STOP. On Bit_ack, finish.
- Finish: on the cycle after the final Bit_ack, I2C_done=1, Busy=0, Bit_cmd=NOP, state IDLE. A new Cmd_valid is accepted in that same cycle.
- Arbitration: Bit_al in any non-IDLE state causes the following on the next edge:
  - I2C_al pulses for one cycle.
  - Busy=0, Bit_cmd=NOP, state IDLE.
  - No I2C_done, and Dout/Rx_ack are unchanged.
  - Bit_al has priority over a simultaneous Bit_ack.
- Bit_ack in IDLE is ignored.
- Latency, write+ack without start/stop: DATA_W+1 Bit_acks, plus 1 cycle to done.

Test Plan:
- DATA_W=8, Cmd_valid with Start=1, Write=1, Stop=1, Din=8'hA5, Bit_rxd=0 on ACK -> Bit_cmd sequence START, 8×WRITE with Bit_txd 1,0,1,0,0,1,0,1, then READ, then STOP. Rx_ack=0, one I2C_done pulse, Busy high throughout.
- DATA_W=8, Read=1, Tx_ack=1, Bit_rxd stream 0,0,1,1,1,1,0,0 -> Dout=8'h3C at I2C_done; ACK phase issues WRITE with Bit_txd=1; no STOP issued.
- Bit_al asserted together with the 4th DATA Bit_ack -> I2C_al pulse on the next cycle, Bit_cmd=NOP, Busy=0, no I2C_done, Dout unchanged.
- Cmd_valid pulsed while Busy=1 -> ignored. Cmd_valid in the I2C_done cycle -> accepted, and the next Bit_cmd matches the new command.
- Rst asserted mid-DATA (bit 5) -> next cycle all outputs at reset values. A subsequent Write of 8'hFF sends 8 ones.
- DATA_W=16, Read=1, Bit_rxd stream for 16'hBEEF -> exactly 16 READ commands then ACK, Dout=16'hBEEF. DATA_W=1 write Din=1 -> one WRITE with Bit_txd=1, then ACK.
